conv1_8_sync: RTL



---
 rtl/conv1_8_sync.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/conv1_8_sync.sv
// ============================================================================
// Module   : conv1_8_sync
// Brief    : Serial-to-byte deserialiser with comma-based alignment and sync
//            detection; optional sync-loss timeout via macro SYNC_LOSS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv1_8_sync #(
  parameter logic [7:0]  COMMA        = 8'hBC,
  parameter int unsigned N_SYNC       = 4,
  parameter int unsigned LOSS_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_serial,
  output logic [7:0] out_data8,
  output logic       out8,
  output logic       active
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    SYNCED = 2'd2
  } state_t;

  localparam logic [3:0] N_SYNC_C = 4'(N_SYNC);

  generate
    if (N_SYNC < 1 || N_SYNC > 15) begin : g_bad_n_sync
      $error("conv1_8_sync: N_SYNC must be in 1..15");
    end
    if (LOSS_TIMEOUT < 1 || LOSS_TIMEOUT > 255) begin : g_bad_loss_timeout
      $error("conv1_8_sync: LOSS_TIMEOUT must be in 1..255");
    end
  endgenerate

  state_t     state_q, state_d;
  logic [6:0] sr_q;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] comma_cnt_q, comma_cnt_d;
  logic [7:0] data_q, data_d;
  logic       out8_q, out8_d;
  logic       active_q;

  logic [7:0] cand;
  logic       is_comma;
  logic       boundary;

  // cand is the byte completed by the bit being sampled on this edge
  assign cand     = {sr_q, in_serial};
  assign is_comma = (cand == COMMA);
  assign boundary = (bit_cnt_q == 3'd7);

`ifdef SYNC_LOSS_EN
  localparam logic [7:0] LOSS_C = 8'(LOSS_TIMEOUT);
  logic [7:0] loss_cnt_q, loss_cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q + 3'd1;
    comma_cnt_d = comma_cnt_q;
    data_d      = data_q;
    out8_d      = 1'b0;
`ifdef SYNC_LOSS_EN
    loss_cnt_d  = loss_cnt_q;
`endif
    case (state_q)
      SEARCH: begin
        // Any bit position may start alignment; the comma fixes the byte phase
        if (is_comma) begin
          bit_cnt_d   = 3'd0;
          comma_cnt_d = 4'd1;
          state_d     = (N_SYNC_C == 4'd1) ? SYNCED : ALIGN;
        end
      end
      ALIGN: begin
        if (boundary) begin
          if (is_comma) begin
            comma_cnt_d = comma_cnt_q + 4'd1;
            if (comma_cnt_d == N_SYNC_C) state_d = SYNCED;
          end else begin
            comma_cnt_d = 4'd0;
            state_d     = SEARCH;
          end
        end
      end
      SYNCED: begin
        if (boundary) begin
          if (!is_comma) begin
            data_d = cand;
            out8_d = 1'b1;
`ifdef SYNC_LOSS_EN
            loss_cnt_d = loss_cnt_q + 8'd1;
            if (loss_cnt_d == LOSS_C) begin
              loss_cnt_d  = 8'd0;
              comma_cnt_d = 4'd0;
              state_d     = SEARCH;
            end
          end else begin
            loss_cnt_d = 8'd0;
`endif
          end
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SEARCH;
      sr_q        <= 7'd0;
      bit_cnt_q   <= 3'd0;
      comma_cnt_q <= 4'd0;
      data_q      <= 8'h00;
      out8_q      <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= cand[6:0];
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      data_q      <= data_d;
      out8_q      <= out8_d;
      active_q    <= (state_d == SYNCED);
    end
  end

`ifdef SYNC_LOSS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) loss_cnt_q <= 8'd0;
    else       loss_cnt_q <= loss_cnt_d;
  end
`endif

  assign out_data8 = data_q;
  assign out8      = out8_q;
  assign active    = active_q;

endmodule

`default_nettype wire
